// File: rtl/sim_run_pkg.sv
// Shared types, state encodings and report strings for the simulation run controller.
package sim_run_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        PASS  = 3'd3,
        FAIL  = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ERR     = 2'd1,
        TIMEOUT = 2'd2,
        WDOG    = 2'd3
    } fail_cause_t;

    // Plain-vector mirrors of the enums, used by the FSM register and the bench.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_PASS  = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;

    localparam logic [1:0] CS_NONE    = 2'd0;
    localparam logic [1:0] CS_ERR     = 2'd1;
    localparam logic [1:0] CS_TIMEOUT = 2'd2;
    localparam logic [1:0] CS_WDOG    = 2'd3;

    localparam string MSG_PASS  = "All finished";
    localparam string MSG_MAGIC = "*-* All Finished *-*";

endpackage

// File: rtl/sim_run_if.sv
// Channel inputs and status outputs of the run controller, bundled for the top-level bench.
interface sim_run_if #(
    parameter int N_CHAN = 4,
    parameter int CNT_W  = 32
);
    import sim_run_pkg::*;

    logic              start;
    logic [N_CHAN-1:0] chan_done;
    logic [N_CHAN-1:0] chan_err;
    logic [N_CHAN-1:0] kick;
    logic [CNT_W-1:0]  cycle_count;
    logic [N_CHAN-1:0] done_mask;
    logic [2:0]        state;
    logic [1:0]        cause;
    logic              finished;
    logic              passed;

    modport master (
        output start, chan_done, chan_err, kick,
        input  cycle_count, done_mask, state, cause, finished, passed
    );

    modport slave (
        input  start, chan_done, chan_err, kick,
        output cycle_count, done_mask, state, cause, finished, passed
    );

endinterface

// File: rtl/sim_run_wdog.sv
// Activity watchdog: counts cycles without a kick while enabled and flags expiry.
module sim_run_wdog
    import sim_run_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WDOG_CYC = 64
) (
    input  logic clk,
    input  logic reset_l,
    input  logic enable,
    input  logic kick_any,
    output logic expire
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);

    logic [CNT_W-1:0] wdog;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wdog <= '0;
        end else if (!enable || kick_any) begin
            wdog <= '0;
        end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
        end
    end

    // A kick on the deciding cycle still rescues the run.
    generate
        if (WDOG_CYC == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = enable && !kick_any && (wdog == WDOG_LAST);
        end
    endgenerate

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: run-cycle counting, sticky done collection, watchdog and PASS/FAIL verdict.
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int N_CHAN     = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 300,
    parameter int WDOG_CYC   = 64,
    parameter int DRAIN_CYC  = 8,
    parameter int FINISH_EN  = 1,
    parameter int REPORT_EN  = 1
) (
    input  logic      clk,
    input  logic      reset_l,
    sim_run_if.slave  bus
);

    localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LAST = (DRAIN_CYC == 0) ? 32'd0 : 32'(DRAIN_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d, cycle_inc;
    logic [N_CHAN-1:0] mask_q, mask_d, mask_all;
    logic [31:0]       drain_q, drain_d;
    logic              finished_q, passed_q;
    logic              err_any, expire;

    sim_run_wdog #(
        .CNT_W    (CNT_W),
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk      (clk),
        .reset_l  (reset_l),
        .enable   (state_q == ST_RUN),
        .kick_any (|bus.kick),
        .expire   (expire)
    );

    assign err_any   = |bus.chan_err;
    assign mask_all  = mask_q | bus.chan_done;
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

    // Priority in RUN: error, all-done, timeout, watchdog.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cycle_d = cycle_q;
        mask_d  = mask_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                cycle_d = '0;
                drain_d = '0;
                if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_inc;
                mask_d  = mask_all;
                if (err_any) begin
                    state_d = ST_FAIL;
                    cause_d = CS_ERR;
                end else if (&mask_all) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else if (cycle_q == CYC_LAST) begin
                    state_d = ST_FAIL;
                    cause_d = CS_TIMEOUT;
                end else if (expire) begin
                    state_d = ST_FAIL;
                    cause_d = CS_WDOG;
                end
            end
            ST_DRAIN: begin
                cycle_d = cycle_inc;
                if (err_any) begin
                    state_d = ST_FAIL;
                    cause_d = CS_ERR;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_PASS;
                end else begin
                    drain_d = drain_q + 32'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            cause_q    <= CS_NONE;
            cycle_q    <= '0;
            mask_q     <= '0;
            drain_q    <= '0;
            finished_q <= 1'b0;
            passed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cycle_q    <= cycle_d;
            mask_q     <= mask_d;
            drain_q    <= drain_d;
            finished_q <= (state_d == ST_PASS) || (state_d == ST_FAIL);
            passed_q   <= (state_d == ST_PASS);
        end
    end

    assign bus.state       = state_q;
    assign bus.cause       = cause_q;
    assign bus.cycle_count = cycle_q;
    assign bus.done_mask   = mask_q;
    assign bus.finished    = finished_q;
    assign bus.passed      = passed_q;

`ifndef SYNTHESIS
    // Report once on the edge that enters a terminal state; reset never gets here.
    always @(posedge clk) begin
        if (reset_l && (state_d != state_q)) begin
            if (state_d == ST_PASS) begin
                if (REPORT_EN != 0) begin
                    $display("%s", MSG_PASS);
                    $display("%s", MSG_MAGIC);
                end
                if (FINISH_EN != 0) begin
                    $finish;
                end
            end else if (state_d == ST_FAIL) begin
                if (REPORT_EN != 0) begin
                    $display("%m FAIL cause=%0d cycle=%0d mask=%h", cause_d, cycle_d, mask_d);
                end
                if (FINISH_EN != 0) begin
                    $finish;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed scoreboard bench for sim_run_ctrl, with a watchdog-enabled and a watchdog-disabled instance.
module tb_sim_run_ctrl;
    import sim_run_pkg::*;

    logic clk = 1'b0;
    logic reset_l = 1'b0;

    always #5 clk = ~clk;

    sim_run_if #(.N_CHAN(4), .CNT_W(32)) bus_a ();
    sim_run_if #(.N_CHAN(4), .CNT_W(32)) bus_b ();

    sim_run_ctrl #(
        .N_CHAN(4), .CNT_W(32), .MAX_CYCLES(300), .WDOG_CYC(64),
        .DRAIN_CYC(8), .FINISH_EN(0), .REPORT_EN(0)
    ) dut_a (
        .clk(clk), .reset_l(reset_l), .bus(bus_a.slave)
    );

    sim_run_ctrl #(
        .N_CHAN(4), .CNT_W(32), .MAX_CYCLES(300), .WDOG_CYC(0),
        .DRAIN_CYC(8), .FINISH_EN(0), .REPORT_EN(0)
    ) dut_b (
        .clk(clk), .reset_l(reset_l), .bus(bus_b.slave)
    );

    typedef struct {
        int          at;
        int          which;
        logic [2:0]  st;
        logic [1:0]  cs;
        logic [31:0] cyc;
        logic [3:0]  mask;
        logic        fin;
        logic        pas;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pass_events = 0;

    always @(posedge bus_a.passed) pass_events++;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int at, input int which, input logic [2:0] st, input logic [1:0] cs,
                            input logic [31:0] cyc, input logic [3:0] mask, input logic fin, input logic pas);
        exp_t e;
        e.at = at; e.which = which; e.st = st; e.cs = cs;
        e.cyc = cyc; e.mask = mask; e.fin = fin; e.pas = pas;
        sb.push_back(e);
    endtask

    task automatic check_output(input string tag, input exp_t e);
        string t;
        t = $sformatf("%s/dut%0d/t%0d", tag, e.which, e.at);
        if (e.which == 0) begin
            compare({t, " state"}, 32'(bus_a.state), 32'(e.st));
            compare({t, " cause"}, 32'(bus_a.cause), 32'(e.cs));
            compare({t, " cycle"}, bus_a.cycle_count, e.cyc);
            compare({t, " mask"}, 32'(bus_a.done_mask), 32'(e.mask));
            compare({t, " finished"}, 32'(bus_a.finished), 32'(e.fin));
            compare({t, " passed"}, 32'(bus_a.passed), 32'(e.pas));
        end else begin
            compare({t, " state"}, 32'(bus_b.state), 32'(e.st));
            compare({t, " cause"}, 32'(bus_b.cause), 32'(e.cs));
            compare({t, " cycle"}, bus_b.cycle_count, e.cyc);
            compare({t, " mask"}, 32'(bus_b.done_mask), 32'(e.mask));
            compare({t, " finished"}, 32'(bus_b.finished), 32'(e.fin));
            compare({t, " passed"}, 32'(bus_b.passed), 32'(e.pas));
        end
    endtask

    task automatic set_inputs(input logic s, input logic [3:0] d, input logic [3:0] e, input logic [3:0] k);
        bus_a.start = s; bus_a.chan_done = d; bus_a.chan_err = e; bus_a.kick = k;
        bus_b.start = s; bus_b.chan_done = d; bus_b.chan_err = e; bus_b.kick = k;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        @(negedge clk);
        reset_l = 1'b0;
        set_inputs(1'b0, 4'h0, 4'h0, 4'h0);
        #1;
        push_exp(-1, 0, ST_IDLE, CS_NONE, 32'd0, 4'h0, 1'b0, 1'b0);
        push_exp(-1, 1, ST_IDLE, CS_NONE, 32'd0, 4'h0, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_output(tag, e);
        end
        @(negedge clk);
        reset_l = 1'b1;
    endtask

    // Cycle t is the cycle_count value seen while that step's inputs are applied.
    task automatic apply_stimulus(input string tag, input int done_at[4], input int err_at, input int err_ch,
                                  input int kick_last, input int noise_from, input int max_t);
        logic       s;
        logic [3:0] d, er, k;
        exp_t       e;
        @(negedge clk);
        set_inputs(1'b1, 4'h0, 4'h0, 4'h0);
        for (int t = 0; t <= max_t; t++) begin
            @(negedge clk);
            s = 1'b0; d = 4'h0; er = 4'h0; k = 4'h0;
            for (int c = 0; c < 4; c++) begin
                if (done_at[c] == t) d[c] = 1'b1;
            end
            if (t == err_at) er[err_ch] = 1'b1;
            if ((t % 5 == 0) && (t <= kick_last)) k[(t / 5) % 4] = 1'b1;
            if ((noise_from >= 0) && (t >= noise_from)) {s, d, er, k} = 13'($urandom);
            set_inputs(s, d, er, k);
            @(posedge clk);
            #1;
            while ((sb.size() > 0) && (sb[0].at <= t)) begin
                e = sb.pop_front();
                check_output(tag, e);
            end
        end
        set_inputs(1'b0, 4'h0, 4'h0, 4'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $error("[TB] FAIL %s unreached observed=none expected=t%0d", tag, e.at);
        end
    endtask

    initial begin
        exp_t e;
        set_inputs(1'b0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        do_reset("reset");

        repeat (3) @(posedge clk);
        #1;
        push_exp(-1, 0, ST_IDLE, CS_NONE, 32'd0, 4'h0, 1'b0, 1'b0);
        e = sb.pop_front();
        check_output("idle_hold", e);

        $display("[TB] all channels done -> drain -> pass");
        push_exp(40, 0, ST_DRAIN, CS_NONE, 32'd41, 4'hf, 1'b0, 1'b0);
        push_exp(48, 0, ST_PASS,  CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        push_exp(48, 1, ST_PASS,  CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        push_exp(55, 0, ST_PASS,  CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        apply_stimulus("pass", '{10, 20, 30, 40}, -1, 0, 1000, -1, 55);

        $display("[TB] three of four done -> timeout");
        do_reset("reset2");
        push_exp(299, 0, ST_FAIL, CS_TIMEOUT, 32'd300, 4'h7, 1'b1, 1'b0);
        push_exp(299, 1, ST_FAIL, CS_TIMEOUT, 32'd300, 4'h7, 1'b1, 1'b0);
        push_exp(305, 0, ST_FAIL, CS_TIMEOUT, 32'd300, 4'h7, 1'b1, 1'b0);
        apply_stimulus("timeout", '{10, 20, 30, -1}, -1, 0, 1000, -1, 305);

        $display("[TB] error with last done");
        do_reset("reset3");
        push_exp(39, 0, ST_RUN,  CS_NONE, 32'd40, 4'h7, 1'b0, 1'b0);
        push_exp(40, 0, ST_FAIL, CS_ERR,  32'd41, 4'hf, 1'b1, 1'b0);
        apply_stimulus("err_last", '{10, 20, 30, 40}, 40, 2, 1000, -1, 45);

        $display("[TB] kicks stop after cycle 5");
        do_reset("reset4");
        push_exp(68,  0, ST_RUN,  CS_NONE,    32'd69,  4'h1, 1'b0, 1'b0);
        push_exp(69,  0, ST_FAIL, CS_WDOG,    32'd70,  4'h1, 1'b1, 1'b0);
        push_exp(299, 1, ST_FAIL, CS_TIMEOUT, 32'd300, 4'h1, 1'b1, 1'b0);
        apply_stimulus("wdog", '{10, -1, -1, -1}, -1, 0, 5, -1, 300);

        $display("[TB] reset in the middle of a run");
        do_reset("reset5");
        push_exp(99, 0, ST_RUN, CS_NONE, 32'd100, 4'h3, 1'b0, 1'b0);
        apply_stimulus("pre_reset", '{10, 20, -1, -1}, -1, 0, 1000, -1, 99);
        do_reset("midrun_reset");
        push_exp(40, 0, ST_DRAIN, CS_NONE, 32'd41, 4'hf, 1'b0, 1'b0);
        push_exp(48, 0, ST_PASS,  CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        apply_stimulus("rerun", '{10, 20, 30, 40}, -1, 0, 1000, -1, 50);

        $display("[TB] error during drain");
        do_reset("reset6");
        push_exp(40, 0, ST_DRAIN, CS_NONE, 32'd41, 4'hf, 1'b0, 1'b0);
        push_exp(43, 0, ST_DRAIN, CS_NONE, 32'd44, 4'hf, 1'b0, 1'b0);
        push_exp(44, 0, ST_FAIL,  CS_ERR,  32'd45, 4'hf, 1'b1, 1'b0);
        apply_stimulus("drain_err", '{10, 20, 30, 40}, 44, 1, 1000, -1, 50);

        $display("[TB] noise after pass");
        do_reset("reset7");
        push_exp(48, 0, ST_PASS, CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        push_exp(70, 0, ST_PASS, CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        push_exp(70, 1, ST_PASS, CS_NONE, 32'd49, 4'hf, 1'b1, 1'b1);
        apply_stimulus("post_pass", '{10, 20, 30, 40}, -1, 0, 1000, 50, 70);

        compare("pass_events", 32'(pass_events), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
